fp_converter_scheduler: RTL and testbench

Arbitrates and sequences access to the shared FP converter. Two requesters, typically the integer-issue path and the FP-issue path, compete for one converter instance. The block grants round-robin, registers the operands into the converter and tracks in-flight operations through a fixed-latency pipeline. It buffers results in a credit-protected response FIFO tagged with requester id, and maintains sticky accrued fflags for fcsr.

---
 rtl/fp_converter_scheduler.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_fp_converter_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_converter_scheduler.sv
// ---------------------------------------------------------------------------
// fp_converter_scheduler
//
// Purpose:
//   Shares one FP converter between two requesters (typically the
//   integer-issue path and the FP-issue path). Requests are granted
//   round-robin, operands are registered into the converter, in-flight
//   operations are tracked through a fixed-latency tag pipeline, and results
//   are buffered in a credit-protected response FIFO tagged with the
//   requester id. Sticky accrued fflags are kept for fcsr.
//
// Parameters:
//   LATENCY  converter pipeline depth in cycles (0..4, 0 = combinational)
//   DEPTH    response FIFO entries (1..8)
//
// Configuration macro:
//   FP_CONV_ACCRUED_FLAGS_EN  when defined, builds the accrued-flags register
//                             and the i_accrued_clear logic; otherwise
//                             o_accrued_flags is tied to 0.
//
// Ports:
//   i_clk                clock, all state updates on the rising edge
//   i_rst                asynchronous reset, active-low
//   i_req_valid[2]       per-requester request valid
//   o_req_ready[2]       per-requester grant (one-hot or zero)
//   i_req_command[2]     per-requester converter command
//   i_req_rounding_mode  per-requester resolved rounding mode
//   i_req_int_src        per-requester integer operand
//   i_req_fp_src         per-requester FP operand
//   o_conv_*             registered issue strobe and operands to converter
//   i_conv_*             converter results and flags
//   o_resp_*             response FIFO head (valid, id, results, flags)
//   i_resp_ready         consumer accepts the head entry
//   o_accrued_flags      sticky OR of consumed response flags
//   i_accrued_clear      clear the accrued flags
// ---------------------------------------------------------------------------

package fp_converter_scheduler_pkg;

  typedef enum logic [3:0] {
    FpConverterCommand_W_S  = 4'd0,
    FpConverterCommand_WU_S = 4'd1,
    FpConverterCommand_S_W  = 4'd2,
    FpConverterCommand_S_WU = 4'd3,
    FpConverterCommand_W_D  = 4'd4,
    FpConverterCommand_WU_D = 4'd5,
    FpConverterCommand_D_W  = 4'd6,
    FpConverterCommand_D_WU = 4'd7,
    FpConverterCommand_S_D  = 4'd8,
    FpConverterCommand_D_S  = 4'd9
  } FpConverterCommand;

  typedef logic [4:0] fflags_t;

endpackage

module fp_converter_scheduler
  import fp_converter_scheduler_pkg::*;
#(
  parameter int LATENCY = 0,
  parameter int DEPTH   = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [1:0]              i_req_valid,
  output logic [1:0]              o_req_ready,
  input  FpConverterCommand [1:0] i_req_command,
  input  logic [1:0][2:0]         i_req_rounding_mode,
  input  logic [1:0][31:0]        i_req_int_src,
  input  logic [1:0][63:0]        i_req_fp_src,
  output logic                    o_conv_valid,
  output FpConverterCommand       o_conv_command,
  output logic [2:0]              o_conv_rounding_mode,
  output logic [31:0]             o_conv_int_src,
  output logic [63:0]             o_conv_fp_src,
  input  logic [31:0]             i_conv_int_result,
  input  logic [63:0]             i_conv_fp_result,
  input  fflags_t                 i_conv_flags,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic                    o_resp_id,
  output logic [31:0]             o_resp_int_result,
  output logic [63:0]             o_resp_fp_result,
  output fflags_t                 o_resp_flags,
  output fflags_t                 o_accrued_flags,
  input  logic                    i_accrued_clear
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic            r_ptr;
  logic [CW-1:0]   r_credits;
  logic            r_convId;

  logic [1:0]      w_eligible;
  logic            w_grantValid;
  logic            w_grantId;
  logic            w_pop;
  logic            w_fifoWrite;
  logic            w_tailValid;
  logic            w_tailId;

  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;
  logic            r_fifoId    [DEPTH];
  logic [31:0]     r_fifoInt   [DEPTH];
  logic [63:0]     r_fifoFp    [DEPTH];
  fflags_t         r_fifoFlags [DEPTH];

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : PW'(p + 1'b1);
  endfunction

  // Round-robin arbiter: the requester named by the pointer wins if it is
  // valid, otherwise the other one. Nothing is eligible without a credit,
  // which is what keeps the response FIFO from ever overflowing.
  always_comb begin
    w_eligible   = (r_credits != '0) ? i_req_valid : 2'b00;
    w_grantValid = 1'b0;
    w_grantId    = r_ptr;
    o_req_ready  = 2'b00;
    if (w_eligible[r_ptr]) begin
      w_grantValid = 1'b1;
      w_grantId    = r_ptr;
    end else if (w_eligible[~r_ptr]) begin
      w_grantValid = 1'b1;
      w_grantId    = ~r_ptr;
    end
    if (w_grantValid) begin
      o_req_ready[w_grantId] = 1'b1;
    end
  end

  // Priority pointer moves to the requester that was not just served, and
  // holds when nothing is granted.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ptr <= 1'b0;
    end else if (w_grantValid) begin
      r_ptr <= ~w_grantId;
    end
  end

  // Credits count free FIFO slots not yet claimed by an in-flight operation.
  // An accept claims one, a pop returns one; both together cancel out.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_credits <= DEPTH_C;
    end else if (w_grantValid && !w_pop) begin
      r_credits <= r_credits - 1'b1;
    end else if (!w_grantValid && w_pop) begin
      r_credits <= r_credits + 1'b1;
    end
  end

  // Issue stage: the granted operands are captured into the converter input
  // registers. Without an accept the strobe drops and the operands hold.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_conv_valid         <= 1'b0;
      o_conv_command       <= FpConverterCommand_W_S;
      o_conv_rounding_mode <= 3'b000;
      o_conv_int_src       <= 32'd0;
      o_conv_fp_src        <= 64'd0;
      r_convId             <= 1'b0;
    end else begin
      o_conv_valid <= w_grantValid;
      if (w_grantValid) begin
        o_conv_command       <= i_req_command[w_grantId];
        o_conv_rounding_mode <= i_req_rounding_mode[w_grantId];
        o_conv_int_src       <= i_req_int_src[w_grantId];
        o_conv_fp_src        <= i_req_fp_src[w_grantId];
        r_convId             <= w_grantId;
      end
    end
  end

  // Tag pipeline shadows the converter so we know when its outputs belong
  // to a real operation and which requester it came from. It never stalls;
  // the credits guarantee there is always room at the tail.
  generate
    if (LATENCY == 0) begin : g_noTag
      assign w_tailValid = o_conv_valid;
      assign w_tailId    = r_convId;
    end else begin : g_tag
      logic [LATENCY-1:0] r_tagValid;
      logic [LATENCY-1:0] r_tagId;

      // Shift {valid, id} one stage per cycle.
      always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
          r_tagValid <= '0;
          r_tagId    <= '0;
        end else begin
          r_tagValid[0] <= o_conv_valid;
          r_tagId[0]    <= r_convId;
          for (int k = 1; k < LATENCY; k++) begin
            r_tagValid[k] <= r_tagValid[k-1];
            r_tagId[k]    <= r_tagId[k-1];
          end
        end
      end

      assign w_tailValid = r_tagValid[LATENCY-1];
      assign w_tailId    = r_tagId[LATENCY-1];
    end
  endgenerate

  assign w_fifoWrite = w_tailValid;
  assign w_pop       = (r_count != '0) && i_resp_ready;

  // FIFO pointers and occupancy. A write and a pop in the same cycle are
  // fine even when full: the popped head slot is the one being rewritten.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_fifoWrite) begin
        r_wrPtr <= nextPtr(r_wrPtr);
      end
      if (w_pop) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
      if (w_fifoWrite && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_fifoWrite && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // FIFO storage: converter outputs are captured together with the tag id
  // on the cycle the tail of the tag pipeline is valid.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifoId[i]    <= 1'b0;
        r_fifoInt[i]   <= 32'd0;
        r_fifoFp[i]    <= 64'd0;
        r_fifoFlags[i] <= '0;
      end
    end else if (w_fifoWrite) begin
      r_fifoId[r_wrPtr]    <= w_tailId;
      r_fifoInt[r_wrPtr]   <= i_conv_int_result;
      r_fifoFp[r_wrPtr]    <= i_conv_fp_result;
      r_fifoFlags[r_wrPtr] <= i_conv_flags;
    end
  end

  assign o_resp_valid      = (r_count != '0);
  assign o_resp_id         = r_fifoId[r_rdPtr];
  assign o_resp_int_result = r_fifoInt[r_rdPtr];
  assign o_resp_fp_result  = r_fifoFp[r_rdPtr];
  assign o_resp_flags      = r_fifoFlags[r_rdPtr];

  // A write into a full FIFO without a simultaneous pop means the credit
  // accounting has been broken somewhere upstream.
  always @(posedge i_clk) begin
    if (i_rst) begin
      assert (!(w_fifoWrite && !w_pop && (r_count == DEPTH_C)));
    end
  end

`ifdef FP_CONV_ACCRUED_FLAGS_EN
  fflags_t r_accrued;

  // Sticky flags accumulate on every pop. A clear coinciding with a pop
  // leaves exactly the popped flags, so no exception is lost.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_accrued <= '0;
    end else if (w_pop) begin
      r_accrued <= i_accrued_clear ? o_resp_flags : (r_accrued | o_resp_flags);
    end else if (i_accrued_clear) begin
      r_accrued <= '0;
    end
  end

  assign o_accrued_flags = r_accrued;
`else
  logic w_unusedClear;

  assign w_unusedClear   = i_accrued_clear;
  assign o_accrued_flags = '0;
`endif

endmodule

// File: tb/tb_fp_converter_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fp_converter_scheduler
//
// Directed bench for fp_converter_scheduler. Two instances share clock,
// reset and request operands: u_dut0 (LATENCY=0, DEPTH=3) and u_dut2
// (LATENCY=2, DEPTH=2). Each has its own valids, resp_ready and clear.
// The converter is a small stand-in model: W_S of 0x40490FDB gives 3 with
// NX, otherwise int = int_src + rm and flags = int_src[4:0]; fp = ~fp_src.
// ---------------------------------------------------------------------------
module tb_fp_converter_scheduler;
  import fp_converter_scheduler_pkg::*;

`ifdef FP_CONV_ACCRUED_FLAGS_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic clock;
  logic rstN;

  FpConverterCommand [1:0] reqCommand;
  logic [1:0][2:0]         reqRm;
  logic [1:0][31:0]        reqInt;
  logic [1:0][63:0]        reqFp;

  logic [1:0] reqValid0, reqReady0, reqValid2, reqReady2;
  logic       respReady0, respReady2, accruedClear0, accruedClear2;

  logic              convValid0, convValid2;
  FpConverterCommand convCommand0, convCommand2;
  logic [2:0]        convRm0, convRm2;
  logic [31:0]       convInt0, convInt2, convIntRes0, convIntRes2;
  logic [63:0]       convFp0, convFp2, convFpRes0, convFpRes2;
  fflags_t           convFlags0, convFlags2;

  logic        respValid0, respValid2, respId0, respId2;
  logic [31:0] respInt0, respInt2;
  logic [63:0] respFp0, respFp2;
  fflags_t     respFlags0, respFlags2, accrued0, accrued2;

  logic [100:0] pipe2a, pipe2b;

  int numCompared;
  int numMismatched;

  fp_converter_scheduler #(.LATENCY(0), .DEPTH(3)) u_dut0 (
    .i_clk(clock), .i_rst(rstN),
    .i_req_valid(reqValid0), .o_req_ready(reqReady0),
    .i_req_command(reqCommand), .i_req_rounding_mode(reqRm),
    .i_req_int_src(reqInt), .i_req_fp_src(reqFp),
    .o_conv_valid(convValid0), .o_conv_command(convCommand0),
    .o_conv_rounding_mode(convRm0), .o_conv_int_src(convInt0),
    .o_conv_fp_src(convFp0),
    .i_conv_int_result(convIntRes0), .i_conv_fp_result(convFpRes0),
    .i_conv_flags(convFlags0),
    .o_resp_valid(respValid0), .i_resp_ready(respReady0),
    .o_resp_id(respId0), .o_resp_int_result(respInt0),
    .o_resp_fp_result(respFp0), .o_resp_flags(respFlags0),
    .o_accrued_flags(accrued0), .i_accrued_clear(accruedClear0)
  );

  fp_converter_scheduler #(.LATENCY(2), .DEPTH(2)) u_dut2 (
    .i_clk(clock), .i_rst(rstN),
    .i_req_valid(reqValid2), .o_req_ready(reqReady2),
    .i_req_command(reqCommand), .i_req_rounding_mode(reqRm),
    .i_req_int_src(reqInt), .i_req_fp_src(reqFp),
    .o_conv_valid(convValid2), .o_conv_command(convCommand2),
    .o_conv_rounding_mode(convRm2), .o_conv_int_src(convInt2),
    .o_conv_fp_src(convFp2),
    .i_conv_int_result(convIntRes2), .i_conv_fp_result(convFpRes2),
    .i_conv_flags(convFlags2),
    .o_resp_valid(respValid2), .i_resp_ready(respReady2),
    .o_resp_id(respId2), .o_resp_int_result(respInt2),
    .o_resp_fp_result(respFp2), .o_resp_flags(respFlags2),
    .o_accrued_flags(accrued2), .i_accrued_clear(accruedClear2)
  );

  function automatic logic [100:0] convModel(input FpConverterCommand cmd,
                                             input logic [2:0] rm,
                                             input logic [31:0] intSrc,
                                             input logic [63:0] fpSrc);
    logic [31:0] intRes;
    logic [4:0]  flags;
    if (cmd == FpConverterCommand_W_S && fpSrc[31:0] == 32'h40490FDB) begin
      intRes = 32'd3;
      flags  = 5'b00001;
    end else begin
      intRes = intSrc + {29'd0, rm};
      flags  = intSrc[4:0];
    end
    return {intRes, ~fpSrc, flags};
  endfunction

  // Free-running clock.
  always #5 clock = ~clock;

  // Combinational converter for the LATENCY=0 instance.
  assign {convIntRes0, convFpRes0, convFlags0} = convModel(convCommand0, convRm0, convInt0, convFp0);

  // Two-stage converter for the LATENCY=2 instance.
  always_ff @(posedge clock) begin
    pipe2a <= convModel(convCommand2, convRm2, convInt2, convFp2);
    pipe2b <= pipe2a;
  end
  assign {convIntRes2, convFpRes2, convFlags2} = pipe2b;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid0, input logic [1:0] valid2,
                               input logic ready0, input logic ready2, input logic clear0);
    @(negedge clock);
    reqValid0     = valid0;
    reqValid2     = valid2;
    respReady0    = ready0;
    respReady2    = ready2;
    accruedClear0 = clear0;
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       id;
    logic [1:0] expReady;
    logic       expValid;
    logic [31:0] expInt;

    numCompared   = 0;
    numMismatched = 0;
    clock         = 1'b0;
    rstN          = 1'b0;
    reqValid0     = 2'b00;
    reqValid2     = 2'b00;
    respReady0    = 1'b0;
    respReady2    = 1'b0;
    accruedClear0 = 1'b0;
    accruedClear2 = 1'b0;
    reqCommand    = {FpConverterCommand_W_S, FpConverterCommand_W_S};
    reqRm         = '0;
    reqInt        = '0;
    reqFp         = '0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clock);
    #1;
    checkOutput("rst_conv_valid0", convValid0, 1'b0);
    checkOutput("rst_conv_int0", convInt0, 32'd0);
    checkOutput("rst_conv_fp0", convFp0, 64'd0);
    checkOutput("rst_resp_valid0", respValid0, 1'b0);
    checkOutput("rst_accrued0", accrued0, 5'b00000);
    checkOutput("rst_credits0", u_dut0.r_credits, 2'd3);
    checkOutput("rst_conv_valid2", convValid2, 1'b0);
    checkOutput("rst_resp_valid2", respValid2, 1'b0);
    rstN = 1'b1;

    // ---------------- single request (LATENCY=0) ----------------
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    reqCommand[0] = FpConverterCommand_W_S;
    reqRm[0]      = 3'b000;
    reqFp[0]      = 64'h40490FDB;
    checkOutput("single_ready", reqReady0, 2'b01);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("single_conv_valid", convValid0, 1'b1);
    checkOutput("single_conv_fp", convFp0, 64'h40490FDB);
    checkOutput("single_conv_cmd", convCommand0, FpConverterCommand_W_S);
    checkOutput("single_resp_early", respValid0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    checkOutput("single_resp_valid", respValid0, 1'b1);
    checkOutput("single_resp_id", respId0, 1'b0);
    checkOutput("single_resp_int", respInt0, 32'd3);
    checkOutput("single_resp_fp", respFp0, 64'hFFFF_FFFF_BFB6_F024);
    checkOutput("single_resp_flags", respFlags0, 5'b00001);
    checkOutput("single_acc_before", accrued0, 5'b00000);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("single_resp_popped", respValid0, 1'b0);
    checkOutput("single_acc_after", accrued0, ACC_EN ? 5'b00001 : 5'b00000);

    // ---------------- contention (pointer is at 1 after the single grant) --
    for (int k = 0; k < 7; k++) begin
      applyStimulus((k < 4) ? 2'b11 : 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
      if (k == 0) begin
        reqInt[0] = 32'h100;
        reqInt[1] = 32'h200;
        reqFp[0]  = 64'd0;
        reqFp[1]  = 64'd0;
      end
      if (k < 4) begin
        checkOutput($sformatf("cont_ready%0d", k), reqReady0, (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      if (k >= 2 && k < 6) begin
        id = ((k - 2) % 2 == 0) ? 1'b1 : 1'b0;
        checkOutput($sformatf("cont_resp_valid%0d", k), respValid0, 1'b1);
        checkOutput($sformatf("cont_resp_id%0d", k), respId0, id);
        checkOutput($sformatf("cont_resp_int%0d", k), respInt0, id ? 32'h200 : 32'h100);
      end else begin
        checkOutput($sformatf("cont_resp_idle%0d", k), respValid0, 1'b0);
      end
    end

    // ---------------- backpressure (LATENCY=2, DEPTH=2) ----------------
    for (int k = 0; k < 14; k++) begin
      applyStimulus(2'b00, (k < 9) ? 2'b01 : 2'b00, 1'b0, (k >= 6), 1'b0);
      reqInt[0] = 32'h40 + 32'(k);
      expReady = (k == 0 || k == 1 || k == 7 || k == 8) ? 2'b01 : 2'b00;
      expValid = (k >= 4 && k <= 7) || k == 11 || k == 12;
      case (k)
        7:       expInt = 32'h41;
        11:      expInt = 32'h47;
        12:      expInt = 32'h48;
        default: expInt = 32'h40;
      endcase
      checkOutput($sformatf("bp_ready%0d", k), reqReady2, expReady);
      checkOutput($sformatf("bp_resp_valid%0d", k), respValid2, expValid);
      if (expValid) begin
        checkOutput($sformatf("bp_resp_int%0d", k), respInt2, expInt);
        checkOutput($sformatf("bp_resp_id%0d", k), respId2, 1'b0);
      end
    end

    // ---------------- clear on pop (LATENCY=0) ----------------
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
    reqInt[0] = 32'h10;
    reqFp[0]  = 64'd0;
    checkOutput("clr_acc_cleared", accrued0, 5'b00000);
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    checkOutput("clr_first_flags", respFlags0, 5'b10000);
    applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
    reqInt[0] = 32'h01;
    checkOutput("clr_acc_nv", accrued0, ACC_EN ? 5'b10000 : 5'b00000);
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    checkOutput("clr_pop_valid", respValid0, 1'b1);
    checkOutput("clr_pop_flags", respFlags0, 5'b00001);
    checkOutput("clr_acc_hold", accrued0, ACC_EN ? 5'b10000 : 5'b00000);
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    checkOutput("clr_acc_result", accrued0, ACC_EN ? 5'b00001 : 5'b00000);

    // ---------------- reset mid-operation (LATENCY=2) ----------------
    applyStimulus(2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
    reqInt[0] = 32'h70;
    reqInt[1] = 32'h71;
    checkOutput("rmid_grant_a", reqReady2, 2'b10);
    applyStimulus(2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
    checkOutput("rmid_grant_b", reqReady2, 2'b01);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    rstN = 1'b0;
    #1;
    checkOutput("rmid_conv_valid", convValid2, 1'b0);
    checkOutput("rmid_conv_int", convInt2, 32'd0);
    checkOutput("rmid_resp_valid", respValid2, 1'b0);
    applyStimulus(2'b00, 2'b11, 1'b0, 1'b1, 1'b0);
    rstN      = 1'b1;
    reqInt[0] = 32'h50;
    reqInt[1] = 32'h61;
    #1;
    checkOutput("rmid_credits", u_dut2.r_credits, 2'd2);
    checkOutput("rmid_first_grant", reqReady2, 2'b01);
    applyStimulus(2'b00, 2'b11, 1'b0, 1'b1, 1'b0);
    checkOutput("rmid_second_grant", reqReady2, 2'b10);
    checkOutput("rmid_no_stale4", respValid2, 1'b0);
    for (int k = 5; k < 10; k++) begin
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      expValid = (k == 7 || k == 8);
      checkOutput($sformatf("rmid_resp_valid%0d", k), respValid2, expValid);
      if (expValid) begin
        checkOutput($sformatf("rmid_resp_id%0d", k), respId2, (k == 8));
        checkOutput($sformatf("rmid_resp_int%0d", k), respInt2, (k == 8) ? 32'h61 : 32'h50);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
